// File: rtl/rgb_pkg.sv
// Shared types and constants for the RGB breathing sequencer.
package rgb_pkg;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StRampUp   = 3'd1,
    StHold     = 3'd2,
    StRampDown = 3'd3,
    StGap      = 3'd4
  } state_e;

  localparam logic [6:0] DUTY_MAX = 7'd100;

  // Channel enables per wheel entry, bit order {R,G,B}.
  localparam logic [2:0] COLOUR_MASK [0:6] = '{
    3'b100, 3'b010, 3'b001, 3'b110, 3'b011, 3'b101, 3'b111
  };

  function automatic logic [2:0] colour_mask(input logic [2:0] idx);
    return (idx > 3'd6) ? 3'b000 : COLOUR_MASK[idx];
  endfunction

  function automatic logic [6:0] clamp_duty(input logic [6:0] duty);
    return (duty > DUTY_MAX) ? DUTY_MAX : duty;
  endfunction

endpackage

// File: rtl/step_prescaler.sv
// Free-running divider producing a one-cycle tick every STEP_CYCLES clocks while enabled.
module step_prescaler #(
  parameter int unsigned STEP_CYCLES = 50_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned CntW = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(STEP_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == CntMax);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rgb_breath_ctrl.sv
// Colour-wheel breathing sequencer: ramps, holds and fades one wheel colour at a time
// and presents per-channel duty plus a constant PWM rate to the pwm_ctr instances.
module rgb_breath_ctrl
  import rgb_pkg::*;
#(
  parameter int unsigned CLK_FRE     = 50_000_000,
  parameter int unsigned PWM_FRE     = 1000,
  parameter int unsigned STEP_CYCLES = 50_000,
  parameter int unsigned HOLD_STEPS  = 200,
  parameter int unsigned GAP_STEPS   = 50
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        single_mode,
  input  logic [2:0]  colour_sel,
  input  logic [6:0]  max_duty,
  output logic [9:0]  duty_r,
  output logic [9:0]  duty_g,
  output logic [9:0]  duty_b,
  output logic [20:0] pwm_rate,
  output logic [2:0]  colour_idx,
  output logic [2:0]  state_o,
  output logic        colour_done,
  output logic        wheel_done
);

  if (CLK_FRE == 0 || PWM_FRE < 1 || PWM_FRE > 500_000 || STEP_CYCLES < 2 ||
      HOLD_STEPS < 1 || GAP_STEPS < 1) begin : gen_param_check
    $error("rgb_breath_ctrl: illegal parameter value");
  end

  localparam int unsigned StepMax = (HOLD_STEPS > GAP_STEPS) ? HOLD_STEPS : GAP_STEPS;
  localparam int unsigned StepW   = (StepMax > 2) ? $clog2(StepMax) : 1;
  localparam logic [StepW-1:0] HoldLast = StepW'(HOLD_STEPS - 1);
  localparam logic [StepW-1:0] GapLast  = StepW'(GAP_STEPS - 1);

  state_e           state_q, state_d;
  logic [6:0]       level_q, level_d;
  logic [6:0]       target_q, target_d;
  logic [StepW-1:0] step_q, step_d;
  logic [2:0]       idx_q, idx_d;
  logic             colour_done_q, colour_done_d;
  logic             wheel_done_q, wheel_done_d;
  logic             tick;
  logic             presc_clr;
  logic [2:0]       mask;

  assign presc_clr = (state_q == StIdle) && enable;

  step_prescaler #(
    .STEP_CYCLES(STEP_CYCLES)
  ) u_step_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (presc_clr),
    .en   (state_q != StIdle),
    .tick (tick)
  );

  always_comb begin
    state_d       = state_q;
    level_d       = level_q;
    target_d      = target_q;
    step_d        = step_q;
    idx_d         = idx_q;
    colour_done_d = 1'b0;
    wheel_done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enable) begin
          state_d  = StRampUp;
          idx_d    = (colour_sel == 3'd7) ? 3'd0 : colour_sel;
          target_d = clamp_duty(max_duty);
          level_d  = '0;
        end
      end
      StRampUp: begin
        // A stop request fades out from wherever the ramp currently is.
        if (!enable) begin
          state_d = StRampDown;
        end else if (tick) begin
          if ({1'b0, level_q} + 8'd1 >= {1'b0, target_q}) begin
            level_d = target_q;
            state_d = StHold;
            step_d  = '0;
          end else begin
            level_d = level_q + 7'd1;
          end
        end
      end
      StHold: begin
        if (!enable) begin
          state_d = StRampDown;
        end else if (tick) begin
          if (step_q == HoldLast) begin
            state_d = StRampDown;
          end else begin
            step_d = step_q + 1'b1;
          end
        end
      end
      StRampDown: begin
        if (tick) begin
          if (level_q <= 7'd1) begin
            level_d = '0;
            state_d = StGap;
            step_d  = '0;
          end else begin
            level_d = level_q - 7'd1;
          end
        end
      end
      StGap: begin
        if (tick) begin
          if (step_q == GapLast) begin
            colour_done_d = 1'b1;
            if (!single_mode) begin
              if (idx_q == 3'd6) begin
                idx_d        = 3'd0;
                wheel_done_d = 1'b1;
              end else begin
                idx_d = idx_q + 3'd1;
              end
            end
            if (enable) begin
              state_d  = StRampUp;
              target_d = clamp_duty(max_duty);
            end else begin
              state_d = StIdle;
            end
          end else begin
            step_d = step_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      level_q       <= '0;
      target_q      <= '0;
      step_q        <= '0;
      idx_q         <= '0;
      colour_done_q <= 1'b0;
      wheel_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      level_q       <= level_d;
      target_q      <= target_d;
      step_q        <= step_d;
      idx_q         <= idx_d;
      colour_done_q <= colour_done_d;
      wheel_done_q  <= wheel_done_d;
    end
  end

  assign mask        = colour_mask(idx_q);
  assign duty_r      = mask[2] ? {3'b000, level_q} : 10'd0;
  assign duty_g      = mask[1] ? {3'b000, level_q} : 10'd0;
  assign duty_b      = mask[0] ? {3'b000, level_q} : 10'd0;
  assign pwm_rate    = 21'(PWM_FRE);
  assign colour_idx  = idx_q;
  assign state_o     = state_q;
  assign colour_done = colour_done_q;
  assign wheel_done  = wheel_done_q;

endmodule

// File: doc/rgb_breath_ctrl.md
Name: rgb_breath_ctrl

Overview:
- Sequencer that drives three pwm_ctr instances (R, G, B) for the RGB LED.
- Steps through a fixed 7-entry colour wheel. Each colour breathes: ramp up, hold, ramp down, gap.
- Produces per-channel duty (0-100) and a shared PWM rate. This block owns all LED brightness policy; the PWM datapath stays dumb.

Parameters:
- CLK_FRE, 50_000_000: system clock frequency in Hz.
- PWM_FRE, 1000: constant PWM frequency driven onto pwm_rate. Legal range 1..500_000; elaboration fails outside this range.
- STEP_CYCLES, 50_000: clk cycles per step tick, i.e. per 1% duty change. Must be >= 2.
- HOLD_STEPS, 200: step ticks held at peak. Must be >= 1.
- GAP_STEPS, 50: step ticks dark between colours. Must be >= 1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous reset, active-low
- enable  in  1  run sequence; deassert requests a graceful stop
- single_mode  in  1  1 = repeat current colour, do not advance
- colour_sel  in  3  start colour index, loaded on IDLE exit; values 7 are treated as 0
- max_duty  in  7  peak duty in %; sampled on entry to RAMP_UP; values >100 clamp to 100
- duty_r  out  10  duty to R pwm_ctr
- duty_g  out  10  duty to G pwm_ctr
- duty_b  out  10  duty to B pwm_ctr
- pwm_rate  out  21  constant PWM_FRE
- colour_idx  out  3  current colour index
- state_o  out  3  FSM state encoding
- colour_done  out  1  one-cycle pulse when a colour's GAP ends
- wheel_done  out  1  one-cycle pulse when colour_idx wraps 6->0; coincides with colour_done

Behaviour:
- Reset (async, rst_n=0): all of the following clear to 0: state=IDLE, level, target, prescaler, step counter, colour_idx, colour_done, wheel_done. Duty outputs are therefore 0.
- Outputs are registered-derived with no combinational path from inputs:
  - duty_x = mask[colour_idx][x] ? level : 0, zero-extended to 10 bits.
  - pwm_rate is the constant PWM_FRE.
- Colour masks {R,G,B}: 0=R 100, 1=G 010, 2=B 001, 3=Y 110, 4=C 011, 5=M 101, 6=W 111.
- Prescaler:
  - Counts 0..STEP_CYCLES-1 while state != IDLE; tick asserts when the count equals STEP_CYCLES-1.
  - Clears to 0 on any IDLE exit.
- FSM:
  - IDLE: if enable, go to RAMP_UP next cycle. On that transition: colour_idx <= colour_sel, target <= clamp(max_duty), level = 0.
  - RAMP_UP, on tick:
    - If level+1 >= target: level <= target, go to HOLD, clear step counter.
    - Otherwise level <= level+1.
    - target=0: first tick goes to HOLD with level 0.
  - HOLD: on tick, step counter increments. When the counter reaches HOLD_STEPS-1 on a tick, go to RAMP_DOWN.
  - RAMP_DOWN: on tick, level <= level-1. When level reaches 0, go to GAP and clear the step counter.
  - GAP, on the tick that ends step GAP_STEPS:
    - Pulse colour_done.
    - If !single_mode, colour_idx <= (idx==6) ? 0 : idx+1; pulse wheel_done on wrap.
    - Then go to RAMP_UP (resampling max_duty) if enable, else IDLE.
- Enable deassert mid-sequence:
  - From RAMP_UP or HOLD: go to RAMP_DOWN on the next clk. The current step is abandoned and level holds its value.
  - RAMP_DOWN and GAP complete normally, then the FSM enters IDLE.
  - No abrupt dark step except on reset.
- Level width: 7 bits. It never exceeds target and never underflows below 0.
- Changes to single_mode are honoured only at GAP exit.
- Changes to max_duty are honoured only at RAMP_UP entry.

Decomposition:
- Package rgb_pkg:
  - state enum: IDLE, RAMP_UP, HOLD, RAMP_DOWN, GAP.
  - COLOUR_MASK[0:6] constant array.
  - DUTY_MAX=100 constant.
- Sub-module step_prescaler (params STEP_CYCLES; ports clk, rst_n, clr, en, tick).
- Top-level FSM and colour logic live in rgb_breath_ctrl.

Test Plan:
(All scenarios use STEP_CYCLES=4, HOLD_STEPS=3, GAP_STEPS=2.)
- Reset/idle: rst_n=0 then 1, enable=0 for 50 cycles -> all duty 0, state_o=IDLE, colour_idx=0, no pulses; pwm_rate=1000.
- Full colour, max_duty=10, colour_sel=0, enable=1:
  - duty_r ramps 1..10 on every 4th clk; duty_g=duty_b=0.
  - Level holds 10 for 12 clks, ramps 9..0, stays dark 8 clks.
  - colour_done fires 100 clks after RAMP_UP entry; colour_idx becomes 1.
- Wheel wrap: colour_sel=6, max_duty=5 -> all three duties equal during W. After its GAP, colour_done and wheel_done pulse together and colour_idx=0.
- Clamp/zero: max_duty=127 -> peak duty 100 exactly. max_duty=0 -> duties stay 0, state passes HOLD/RAMP_DOWN/GAP, colour_done still fires after 3+1+2 ticks.
- Graceful stop: enable drop at level 7 in RAMP_UP -> next clk RAMP_DOWN, level 6..0 on ticks, GAP, then IDLE; no advance to RAMP_UP.
- Reset mid-HOLD with level=10: rst_n low asynchronously -> duties 0 before the next clk edge; after release, state is IDLE and colour_idx=0. single_mode=1 keeps colour_idx constant across 3 colour_done pulses.
